bit_column_scheduler: RTL and testbench

//  Upstream feeder of the bit-column dot-product stage. Accepts one group of 8 sign-magnitude

---
 rtl/bit_column_scheduler.sv | 136 +++++++++++++
 tb/tb_bit_column_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_column_scheduler.sv
// Bit-column scheduler: splits a group of sign-magnitude weights into non-zero
// magnitude bit-columns, one column per beat, with activations and signs held per group.
module bit_column_scheduler #(
  parameter int unsigned LANES   = 8,
  parameter int unsigned MAG_W   = 7,
  parameter int unsigned ACT_W   = 8,
  parameter int unsigned SHIFT_W = 3
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*(MAG_W+1)-1:0]  in_weights,
  input  logic [LANES*ACT_W-1:0]      in_acts,
  output logic                        col_valid,
  input  logic                        out_ready,
  output logic [LANES*ACT_W-1:0]      activations,
  output logic [LANES-1:0]            weight_column,
  output logic [LANES-1:0]            weight_sign,
  output logic [SHIFT_W-1:0]          shift_offset,
  output logic                        col_first,
  output logic                        col_last,
  output logic [15:0]                 skip_count
);

  localparam int unsigned WW    = MAG_W + 1;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned PC_W  = SHIFT_W + 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                   state;
  logic [LANES*MAG_W-1:0]   mags_q;
  logic [MAG_W-1:0]         pending;

  logic [LANES*MAG_W-1:0]   in_mags;
  logic [LANES-1:0]         in_signs;
  logic [MAG_W-1:0]         in_mask;
  logic [MAG_W-1:0]         nxt_pend;
  logic [CNT_W:0]           skip_sum;
  logic                     accept;
  logic                     beat;

  // Index of the lowest set bit; 0 when nothing is set (empty group).
  function automatic logic [SHIFT_W-1:0] low_idx(input logic [MAG_W-1:0] p);
    logic [SHIFT_W-1:0] r;
    r = '0;
    for (int b = int'(MAG_W) - 1; b >= 0; b--) begin
      if (p[b]) r = SHIFT_W'(b);
    end
    return r;
  endfunction

  function automatic logic at_most_one(input logic [MAG_W-1:0] p);
    return (p & (p - MAG_W'(1))) == '0;
  endfunction

  function automatic logic [PC_W-1:0] popcnt(input logic [MAG_W-1:0] p);
    logic [PC_W-1:0] c;
    c = '0;
    for (int b = 0; b < int'(MAG_W); b++) c = c + PC_W'(p[b]);
    return c;
  endfunction

  function automatic logic [LANES-1:0] column(input logic [LANES*MAG_W-1:0] m,
                                              input logic [SHIFT_W-1:0]     off);
    logic [LANES-1:0] c;
    logic [MAG_W-1:0] lm;
    c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      lm   = m[i*MAG_W +: MAG_W];
      c[i] = lm[off];
    end
    return c;
  endfunction

  // Unpack incoming group and form the non-zero column mask.
  always_comb begin
    in_mags  = '0;
    in_signs = '0;
    in_mask  = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      in_mags[i*MAG_W +: MAG_W] = in_weights[i*WW +: MAG_W];
      in_signs[i]               = in_weights[i*WW + MAG_W];
      in_mask                   = in_mask | in_weights[i*WW +: MAG_W];
    end
    nxt_pend = pending & (pending - MAG_W'(1));
    skip_sum = {1'b0, skip_count} + (CNT_W+1)'(MAG_W) - (CNT_W+1)'(popcnt(in_mask));
    in_ready = (state == IDLE) | ((state == ISSUE) & col_last & out_ready);
    accept   = in_valid & in_ready;
    beat     = col_valid & out_ready;
  end

  // Group FSM; a new group takes priority over retiring the last beat (no bubble).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      mags_q        <= '0;
      pending       <= '0;
      activations   <= '0;
      weight_column <= '0;
      weight_sign   <= '0;
      shift_offset  <= '0;
      col_valid     <= 1'b0;
      col_first     <= 1'b0;
      col_last      <= 1'b0;
      skip_count    <= '0;
    end else if (accept) begin
      state         <= ISSUE;
      mags_q        <= in_mags;
      pending       <= in_mask;
      activations   <= in_acts;
      weight_sign   <= in_signs;
      shift_offset  <= low_idx(in_mask);
      weight_column <= column(in_mags, low_idx(in_mask));
      col_valid     <= 1'b1;
      col_first     <= 1'b1;
      col_last      <= at_most_one(in_mask);
      skip_count    <= skip_sum[CNT_W] ? {CNT_W{1'b1}} : skip_sum[CNT_W-1:0];
    end else if (beat) begin
      col_first <= 1'b0;
      if (col_last) begin
        state     <= IDLE;
        pending   <= '0;
        col_valid <= 1'b0;
        col_last  <= 1'b0;
      end else begin
        pending       <= nxt_pend;
        shift_offset  <= low_idx(nxt_pend);
        weight_column <= column(mags_q, low_idx(nxt_pend));
        col_last      <= at_most_one(nxt_pend);
      end
    end
  end

endmodule

// File: tb/tb_bit_column_scheduler.sv
// Bench for bit_column_scheduler: directed table, stall/back-to-back/reset sequences,
// and randomized traffic against a beat-queue reference model.
module tb_bit_column_scheduler;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_weights;
  logic [63:0] in_acts;
  logic        col_valid;
  logic        out_ready;
  logic [63:0] activations;
  logic [7:0]  weight_column;
  logic [7:0]  weight_sign;
  logic [2:0]  shift_offset;
  logic        col_first;
  logic        col_last;
  logic [15:0] skip_count;

  bit_column_scheduler dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_weights(in_weights), .in_acts(in_acts),
    .col_valid(col_valid), .out_ready(out_ready),
    .activations(activations), .weight_column(weight_column),
    .weight_sign(weight_sign), .shift_offset(shift_offset),
    .col_first(col_first), .col_last(col_last), .skip_count(skip_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] acts;
    logic [7:0]  col;
    logic [7:0]  sign;
    logic [2:0]  off;
    logic        first;
    logic        last;
  } beat_t;

  typedef struct {
    logic [7:0][6:0] mag;
    logic [7:0]      signs;
    logic [63:0]     acts;
    int              nbeats;
    logic [2:0]      f_off;
    logic [7:0]      f_col;
    logic [2:0]      l_off;
    logic [7:0]      l_col;
    int              skip_d;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  beat_t q[$];
  int    exp_skip;
  logic  acc_flag, acc_overlap;
  logic  hold_valid;
  logic [127:0] hold_snap;
  int    cap_cnt;
  logic [2:0] cap_f_off, cap_l_off;
  logic [7:0] cap_f_col, cap_l_col, cap_sign;
  vec_t  tbl[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: list the non-zero columns in ascending bit order, one beat each.
  function automatic void push_group(input logic [63:0] w, input logic [63:0] a);
    logic [6:0] mask;
    logic [7:0] signs;
    int         bits[$];
    beat_t      b;
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      mask     = mask | w[i*8 +: 7];
      signs[i] = w[i*8 + 7];
    end
    for (int k = 0; k < 7; k++) if (mask[k]) bits.push_back(k);
    if (bits.size() == 0) begin
      b = '{acts: a, col: 8'h00, sign: signs, off: 3'd0, first: 1'b1, last: 1'b1};
      q.push_back(b);
    end else begin
      for (int k = 0; k < bits.size(); k++) begin
        b.acts = a; b.sign = signs; b.off = 3'(bits[k]);
        for (int i = 0; i < 8; i++) b.col[i] = w[i*8 + bits[k]];
        b.first = (k == 0);
        b.last  = (k == bits.size() - 1);
        q.push_back(b);
      end
    end
    exp_skip = exp_skip + 7 - bits.size();
    if (exp_skip > 65535) exp_skip = 65535;
  endfunction

  function automatic logic [127:0] snap();
    return {43'd0, activations, weight_column, weight_sign, shift_offset, col_first, col_last};
  endfunction

  // One clock: check handshake and outputs against the model, then advance.
  task automatic tick();
    beat_t b;
    logic  exp_ir;
    #1;
    acc_flag = 1'b0;
    check("skip_count", skip_count, 128'(exp_skip));
    check("col_valid", col_valid, q.size() != 0);
    exp_ir = (q.size() == 0) || (q.size() == 1 && out_ready);
    check("in_ready", in_ready, exp_ir);
    if (hold_valid && col_valid) check("stall_stable", snap(), hold_snap);
    if (col_valid && out_ready && q.size() > 0) begin
      b = q.pop_front();
      check("beat_offset", shift_offset, b.off);
      check("beat_column", weight_column, b.col);
      check("beat_sign", weight_sign, b.sign);
      check("beat_acts", activations, b.acts);
      check("beat_first", col_first, b.first);
      check("beat_last", col_last, b.last);
      if (col_first) begin cap_f_off = shift_offset; cap_f_col = weight_column; end
      cap_l_off = shift_offset; cap_l_col = weight_column; cap_sign = weight_sign;
      cap_cnt++;
    end
    hold_valid = col_valid && !out_ready;
    hold_snap  = snap();
    if (in_valid && in_ready) begin
      acc_flag    = 1'b1;
      acc_overlap = col_valid;
      push_group(in_weights, in_acts);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] pack_w(input vec_t v);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = {v.signs[i], v.mag[i]};
    return w;
  endfunction

  task automatic send_group(input logic [63:0] w, input logic [63:0] a);
    int n;
    in_weights = w; in_acts = a; in_valid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!acc_flag && n < 100);
    if (!acc_flag) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin tick(); n++; end
    check("drain_done", q.size(), 0);
  endtask

  initial begin
    logic [63:0] w, a;
    logic [6:0]  gm;
    logic [15:0] sk0;

    for (int i = 0; i < 8; i++) begin
      tbl[0].mag[i] = 7'h05; tbl[1].mag[i] = 7'h00; tbl[2].mag[i] = 7'h00;
      tbl[3].mag[i] = 7'h00; tbl[4].mag[i] = 7'h00;
    end
    tbl[0].signs = 8'hA5; tbl[0].acts = 64'h0807060504030201; tbl[0].nbeats = 2;
    tbl[0].f_off = 3'd0; tbl[0].f_col = 8'hFF; tbl[0].l_off = 3'd2; tbl[0].l_col = 8'hFF; tbl[0].skip_d = 5;
    tbl[1].signs = 8'h00; tbl[1].acts = 64'h1111111111111111; tbl[1].nbeats = 1;
    tbl[1].f_off = 3'd0; tbl[1].f_col = 8'h00; tbl[1].l_off = 3'd0; tbl[1].l_col = 8'h00; tbl[1].skip_d = 7;
    tbl[2].mag[3] = 7'h40;
    tbl[2].signs = 8'h08; tbl[2].acts = 64'hDEADBEEF01234567; tbl[2].nbeats = 1;
    tbl[2].f_off = 3'd6; tbl[2].f_col = 8'h08; tbl[2].l_off = 3'd6; tbl[2].l_col = 8'h08; tbl[2].skip_d = 6;
    tbl[3].mag[0] = 7'h7F;
    tbl[3].signs = 8'h81; tbl[3].acts = 64'h1122334455667788; tbl[3].nbeats = 7;
    tbl[3].f_off = 3'd0; tbl[3].f_col = 8'h01; tbl[3].l_off = 3'd6; tbl[3].l_col = 8'h01; tbl[3].skip_d = 0;
    tbl[4].mag[1] = 7'h12; tbl[4].mag[7] = 7'h48;
    tbl[4].signs = 8'h7E; tbl[4].acts = 64'hA0B0C0D0E0F00010; tbl[4].nbeats = 4;
    tbl[4].f_off = 3'd1; tbl[4].f_col = 8'h02; tbl[4].l_off = 3'd6; tbl[4].l_col = 8'h80; tbl[4].skip_d = 3;

    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_weights = '0; in_acts = '0;
    exp_skip = 0; hold_valid = 1'b0; acc_overlap = 1'b0; cap_cnt = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    check("rst_col_valid", col_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_skip", skip_count, 0);
    check("rst_outputs", {activations, weight_column, weight_sign, shift_offset, col_first, col_last}, 0);

    // Directed table with downstream always ready.
    for (int t = 0; t < 5; t++) begin
      cap_cnt = 0;
      sk0 = skip_count;
      send_group(pack_w(tbl[t]), tbl[t].acts);
      drain();
      check($sformatf("t%0d_beats", t), cap_cnt, tbl[t].nbeats);
      check($sformatf("t%0d_first_off", t), cap_f_off, tbl[t].f_off);
      check($sformatf("t%0d_first_col", t), cap_f_col, tbl[t].f_col);
      check($sformatf("t%0d_last_off", t), cap_l_off, tbl[t].l_off);
      check($sformatf("t%0d_last_col", t), cap_l_col, tbl[t].l_col);
      check($sformatf("t%0d_sign", t), cap_sign, tbl[t].signs);
      check($sformatf("t%0d_skip_delta", t), 16'(skip_count - sk0), tbl[t].skip_d);
    end

    // Stall beat 1 for three cycles.
    cap_cnt = 0;
    send_group(pack_w(tbl[0]), tbl[0].acts);
    out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    drain();
    check("stall_beats", cap_cnt, 2);

    // Two groups back-to-back with in_valid held.
    in_weights = pack_w(tbl[0]); in_acts = tbl[0].acts; in_valid = 1'b1;
    tick();
    check("b2b_first_acc", acc_flag, 1);
    in_weights = pack_w(tbl[4]); in_acts = tbl[4].acts;
    for (int n = 0; n < 10 && !acc_flag; n++) tick();
    acc_overlap = 1'b0;
    begin
      int n;
      n = 0;
      do begin tick(); n++; end while (!acc_flag && n < 10);
    end
    check("b2b_no_bubble", acc_overlap, 1);
    in_valid = 1'b0;
    drain();

    // Randomized traffic with sparse magnitudes.
    for (int n = 0; n < 400; n++) begin
      gm = 7'($urandom) & 7'($urandom);
      if ($urandom_range(0, 4) == 0) gm = '0;
      for (int i = 0; i < 8; i++) w[i*8 +: 8] = {1'($urandom), 7'($urandom) & gm};
      a = {$urandom, $urandom};
      in_weights = w; in_acts = a;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // Drive the skip counter into saturation with empty groups.
    in_weights = '0; in_acts = 64'h5A5A5A5A5A5A5A5A; in_valid = 1'b1;
    for (int n = 0; n < 9400; n++) tick();
    in_valid = 1'b0;
    drain();
    check("skip_saturated", skip_count, 16'hFFFF);

    // Reset during beat 1 discards the group.
    send_group(pack_w(tbl[0]), tbl[0].acts);
    check("mid_rst_in_beat", col_valid, 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_col_valid", col_valid, 0);
    check("mid_rst_skip", skip_count, 0);
    q.delete(); exp_skip = 0; hold_valid = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_hold_valid", col_valid, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) tick();
    check("post_rst_in_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
